if_stage: RTL
=============

Name: if_stage

Overview:
Instruction-fetch stage of the LEGv8 processor, directly upstream of the Control decoder.
- Holds the PC and issues one request at a time to a variable-latency instruction memory.
- Registers the returned 32-bit word into an IF/ID register and drives the 11-bit Opcode field (Instr[31:21]) consumed by Control.
- Supports downstream stall via a one-entry skid buffer, and branch redirect/flush driven by the branch-resolution logic (Branch & Zero).

Parameters:
ADDR_WIDTH, 64, PC and memory address width
RESET_PC, 0, PC value loaded on reset
PC_INC, 4, byte increment per sequential instruction

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
ImemReq  output  1  one-cycle request pulse to instruction memory
ImemAddr  output  ADDR_WIDTH  fetch address; valid while ImemReq=1
ImemRdata  input  32  instruction word returned by memory
ImemValid  input  1  one-cycle response strobe; exactly one per request, at least 1 cycle after ImemReq
Stall  input  1  downstream cannot accept a new IF/ID entry this cycle
BranchTaken  input  1  one-cycle redirect strobe
BranchTarget  input  ADDR_WIDTH  redirect address, sampled when BranchTaken=1
Instr  output  32  IF/ID instruction register
PCOut  output  ADDR_WIDTH  PC of the instruction in Instr
Opcode  output  11  Instr[31:21] when IfValid=1, else 11'b0 (bubble)
IfValid  output  1  IF/ID register holds a live instruction

Behaviour:
- Reset (async, rst_n=0): PC=RESET_PC, Instr=0, PCOut=0, IfValid=0, ImemReq=0, skid buffer empty, state=IDLE. Opcode is 0 during reset.
- FSM states:
  - IDLE: the first cycle after reset release, go to REQ.
  - REQ: ImemReq=1 and ImemAddr=PC for exactly one cycle, then go to WAIT.
  - WAIT: wait for ImemValid.
  - FULL: a response is held in the skid buffer.
  - DROP: discard one outstanding response.
- WAIT + ImemValid:
  - IF/ID free (IfValid=0 or Stall=0): load Instr=ImemRdata, PCOut=PC, IfValid=1; PC<=PC+PC_INC; go to REQ.
  - IfValid=1 and Stall=1: write word and PC into the skid buffer; PC<=PC+PC_INC; go to FULL.
- FULL: when Stall=0, move skid contents into IF/ID (IfValid=1), empty the skid buffer, go to REQ. No memory request is issued while in FULL.
- Consumption: when IfValid=1 and Stall=0 and no new word is loaded that cycle, IfValid<=0.
- Stall=1: Instr, PCOut and IfValid hold their values.
- Minimum fetch latency is 2 cycles per instruction (REQ then response); one request is outstanding at most.
- BranchTaken=1 has the highest priority over Stall, ImemValid and FULL:
  - PC<=BranchTarget with bits[1:0] forced to 0; IfValid<=0; skid buffer emptied.
  - In REQ, or in WAIT without ImemValid: go to DROP. The next ImemValid is discarded, then go to REQ at the new PC.
  - In WAIT with a simultaneous ImemValid: the response is discarded; go to REQ.
  - In IDLE or FULL: go to REQ.
  - In DROP: PC is updated; remain in DROP.
- BranchTaken in the same cycle as Stall=1: the flush still occurs.
- PC arithmetic is modulo 2^ADDR_WIDTH; wrap from all-ones-minus-3 to 0 is silent.
- ImemAddr is 0 whenever ImemReq=0.
- rst_n asserted mid-operation: immediate return to reset values. A memory response arriving after reset release with no request pending is ignored (state IDLE or REQ).

Test Plan:
- Reset then sequential fetch, memory latency 1, words F8400000/F8000000/8B000000 -> ImemAddr 0,4,8; Opcode 11111000010, 11111000000, 10001011000; PCOut 0,4,8; IfValid pulses once per word.
- Stall=1 for 5 cycles while 8B000000 is held and CB000000 returns -> Instr stays 8B000000 and no ImemReq during FULL; after Stall drops, Instr=CB000000 (Opcode 11001011000) and the next ImemReq has addr 0x10.
- BranchTaken with target 0x40 while in WAIT, memory returns 8A000000 two cycles later -> that word is discarded, IfValid=0, next ImemReq addr 0x40, loaded B4000000 gives Opcode 10110100000, PCOut 0x40.
- BranchTaken in the same cycle as ImemValid and Stall=1 with skid full, target 0x103 -> IfValid=0, skid empty, next ImemAddr 0x100.
- rst_n pulsed low while in WAIT at PC 0x20, stray ImemValid one cycle after release -> IfValid stays 0, first ImemAddr = RESET_PC (0), stray word never appears on Instr.
- RESET_PC = 2^64-4 -> second ImemAddr wraps to 0.

Source files
------------

// File: rtl/if_stage_if.sv
// if_stage_if: instruction-memory request/response bus between the fetch stage and imem
interface if_stage_if #(parameter int ADDR_WIDTH = 64) ();
  logic                  ImemReq;
  logic [ADDR_WIDTH-1:0] ImemAddr;
  logic [31:0]           ImemRdata;
  logic                  ImemValid;
  modport master (output ImemReq, ImemAddr, input ImemRdata, ImemValid);
  modport slave (input ImemReq, ImemAddr, output ImemRdata, ImemValid);
endinterface

// File: rtl/if_stage.sv
// if_stage: LEGv8 fetch stage with one outstanding imem request, skid buffer and branch flush
module if_stage #(
  parameter int                    ADDR_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    PC_INC     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  if_stage_if.master            imem,
  input  logic                  Stall,
  input  logic                  BranchTaken,
  input  logic [ADDR_WIDTH-1:0] BranchTarget,
  output logic [31:0]           Instr,
  output logic [ADDR_WIDTH-1:0] PCOut,
  output logic [10:0]           Opcode,
  output logic                  IfValid
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, FULL, DROP} state_t;
  state_t                state;
  logic                  req;
  logic [ADDR_WIDTH-1:0] pc;
  logic [31:0]           skid_instr;
  logic [ADDR_WIDTH-1:0] skid_pc;
  logic                  drop;
  assign imem.ImemReq  = req;
  assign imem.ImemAddr = req ? pc : '0;
  assign Opcode        = IfValid ? Instr[31:21] : 11'b0;
  // a redirect must wait out a response that is already in flight
  assign drop = state == REQ || ((state == WAIT || state == DROP) && !imem.ImemValid);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      req        <= 1'b0;
      pc         <= RESET_PC;
      Instr      <= '0;
      PCOut      <= '0;
      IfValid    <= 1'b0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else begin
      req <= 1'b0;
      if (IfValid && !Stall) IfValid <= 1'b0;
      if (BranchTaken) begin
        pc      <= BranchTarget & ~ADDR_WIDTH'(3);
        IfValid <= 1'b0;
        state   <= drop ? DROP : REQ;
        req     <= !drop;
      end else case (state)
        IDLE: begin
          state <= REQ;
          req   <= 1'b1;
        end
        REQ: state <= WAIT;
        WAIT: if (imem.ImemValid) begin
          pc <= pc + ADDR_WIDTH'(PC_INC);
          if (IfValid && Stall) begin
            skid_instr <= imem.ImemRdata;
            skid_pc    <= pc;
            state      <= FULL;
          end else begin
            Instr   <= imem.ImemRdata;
            PCOut   <= pc;
            IfValid <= 1'b1;
            state   <= REQ;
            req     <= 1'b1;
          end
        end
        FULL: if (!Stall) begin
          Instr   <= skid_instr;
          PCOut   <= skid_pc;
          IfValid <= 1'b1;
          state   <= REQ;
          req     <= 1'b1;
        end
        DROP: if (imem.ImemValid) begin
          state <= REQ;
          req   <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
